// File: rtl/rv0_pkg.sv
// rv0_pkg: shared floating-point formats and boxing constants for the rv0 core
package rv0_pkg;
    typedef enum logic {FMT_S = 1'b0, FMT_D = 1'b1} fp_fmt_t;
    localparam int RV0_FLEN = 64;
    localparam logic [31:0] RV0_FP_CNAN_S = 32'h7FC0_0000;
    localparam logic [31:0] RV0_FP_BOX = 32'hFFFF_FFFF;
endpackage

// File: rtl/rv0_rf_f_rp.sv
// rv0_rf_f_rp: one FP register file read port with write bypass and NaN unboxing
module rv0_rf_f_rp
    import rv0_pkg::*;
#(
    parameter int FLEN = RV0_FLEN,
    parameter int NREG = 32,
    parameter int NWP = 2,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREG)
)(
    input  logic [NREG-1:0][FLEN-1:0] rf_i,
    input  logic [NREG-1:0]           busy_i,
    input  logic [AW-1:0]             addr_i,
    input  logic                      fmt_i,
    input  logic [NWP-1:0]            wvld_i,
    input  logic [NWP-1:0][AW-1:0]    waddr_i,
    input  logic [NWP-1:0][FLEN-1:0]  wdata_i,
    output logic [FLEN-1:0]           data_o,
    output logic                      busy_o
);
    logic [FLEN-1:0] raw;

    // wdata_i arrives already boxed, so forwarded and stored values unbox identically
    always_comb begin
        raw = rf_i[addr_i];
        busy_o = busy_i[addr_i];
        for (int i = 0; i < NWP; i++)
            if (BYPASS != 0 && wvld_i[i] && waddr_i[i] == addr_i) begin
                raw = wdata_i[i];
                busy_o = 1'b0;
            end
    end

    if (FLEN == 64) begin : g_unbox
        assign data_o = (fp_fmt_t'(fmt_i) == FMT_D || raw[63:32] == RV0_FP_BOX) ? raw
                      : {RV0_FP_BOX, RV0_FP_CNAN_S};
    end else begin : g_pass
        assign data_o = raw;
    end
endmodule

// File: rtl/rv0_rf_f_mp.sv
// rv0_rf_f_mp: multi-ported FP register file with NaN boxing, busy scoreboard and FS dirty tracking
module rv0_rf_f_mp
    import rv0_pkg::*;
#(
    parameter int FLEN = RV0_FLEN,
    parameter int NREG = 32,
    parameter int NRP = 3,
    parameter int NWP = 2,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREG)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRP-1:0][AW-1:0]   rp_addr,
    input  logic [NRP-1:0]           rp_fmt,
    output logic [NRP-1:0][FLEN-1:0] rp_data,
    output logic [NRP-1:0]           rp_busy,
    input  logic [NWP-1:0]           wp_vld,
    input  logic [NWP-1:0][AW-1:0]   wp_addr,
    input  logic [NWP-1:0]           wp_fmt,
    input  logic [NWP-1:0][FLEN-1:0] wp_data,
    input  logic                     rsv_vld,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     flush,
    input  logic                     fs_clean,
    output logic                     fs_dirty
);
    logic [NREG-1:0][FLEN-1:0] rf_q;
    logic [NREG-1:0]           busy_q, busy_d;
    logic                      fs_dirty_q, fs_dirty_d;
    logic [NWP-1:0][FLEN-1:0]  wdat;

    for (genvar p = 0; p < NWP; p++) begin : g_wbox
        if (FLEN == 64) begin : g_64
            assign wdat[p] = (fp_fmt_t'(wp_fmt[p]) == FMT_D) ? wp_data[p]
                           : {RV0_FP_BOX, wp_data[p][31:0]};
        end else begin : g_32
            assign wdat[p] = wp_data[p];
        end
    end

    // later ports overwrite earlier ones, so the highest index wins a collision
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            rf_q <= '0;
        else
            for (int i = 0; i < NWP; i++)
                if (wp_vld[i]) rf_q[wp_addr[i]] <= wdat[i];

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NWP; i++)
            if (wp_vld[i]) busy_d[wp_addr[i]] = 1'b0;
        if (rsv_vld) busy_d[rsv_addr] = 1'b1;
        if (flush) busy_d = '0;
    end

    assign fs_dirty_d = (|wp_vld) | (fs_dirty_q & ~fs_clean);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            busy_q <= '0;
            fs_dirty_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            fs_dirty_q <= fs_dirty_d;
        end

    assign fs_dirty = fs_dirty_q;

    for (genvar r = 0; r < NRP; r++) begin : g_rp
        rv0_rf_f_rp #(.FLEN(FLEN), .NREG(NREG), .NWP(NWP), .BYPASS(BYPASS)) u_rp (
            .rf_i   (rf_q),
            .busy_i (busy_q),
            .addr_i (rp_addr[r]),
            .fmt_i  (rp_fmt[r]),
            .wvld_i (wp_vld),
            .waddr_i(wp_addr),
            .wdata_i(wdat),
            .data_o (rp_data[r]),
            .busy_o (rp_busy[r])
        );
    end

    if (FLEN == 32) begin : g_fmt_chk
        a_no_d_write: assert property (@(posedge clk) disable iff (!rst_n) (wp_vld & wp_fmt) == '0);
    end
endmodule

// File: tb/tb_rv0_rf_f_mp.sv
// tb_rv0_rf_f_mp: randomized and directed check of rv0_rf_f_mp against a behavioural model
module tb_rv0_rf_f_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0][4:0]  rp_addr;
    logic [2:0]       rp_fmt;
    logic [2:0][63:0] rp_data;
    logic [2:0]       rp_busy;
    logic [1:0]       wp_vld;
    logic [1:0][4:0]  wp_addr;
    logic [1:0]       wp_fmt;
    logic [1:0][63:0] wp_data;
    logic             rsv_vld;
    logic [4:0]       rsv_addr;
    logic             flush;
    logic             fs_clean;
    logic             fs_dirty;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_rf [32];
    bit          m_busy [32];
    bit          m_dirty;

    localparam logic [63:0] CNAN_BOX = 64'hFFFF_FFFF_7FC0_0000;

    rv0_rf_f_mp dut (
        .clk(clk), .rst_n(rst_n),
        .rp_addr(rp_addr), .rp_fmt(rp_fmt), .rp_data(rp_data), .rp_busy(rp_busy),
        .wp_vld(wp_vld), .wp_addr(wp_addr), .wp_fmt(wp_fmt), .wp_data(wp_data),
        .rsv_vld(rsv_vld), .rsv_addr(rsv_addr), .flush(flush),
        .fs_clean(fs_clean), .fs_dirty(fs_dirty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] stored(input bit fmt, input logic [63:0] d);
        return fmt ? d : {32'hFFFF_FFFF, d[31:0]};
    endfunction

    function automatic logic [63:0] view(input bit fmt, input logic [63:0] v);
        if (fmt) return v;
        return (v[63:32] == 32'hFFFF_FFFF) ? v : CNAN_BOX;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = '0;
            m_busy[r] = 1'b0;
        end
        m_dirty = 1'b0;
    endtask

    task automatic check_reads(input string tag);
        for (int p = 0; p < 3; p++) begin
            logic [63:0] v;
            bit b;
            v = m_rf[rp_addr[p]];
            b = m_busy[rp_addr[p]];
            for (int i = 0; i < 2; i++)
                if (wp_vld[i] && wp_addr[i] == rp_addr[p]) begin
                    v = stored(wp_fmt[i], wp_data[i]);
                    b = 1'b0;
                end
            chk({tag, "_data"}, rp_data[p], view(rp_fmt[p], v));
            chk({tag, "_busy"}, rp_busy[p], b);
        end
        chk({tag, "_fs"}, fs_dirty, m_dirty);
    endtask

    task automatic commit();
        for (int i = 0; i < 2; i++)
            if (wp_vld[i]) begin
                m_rf[wp_addr[i]] = stored(wp_fmt[i], wp_data[i]);
                m_busy[wp_addr[i]] = 1'b0;
            end
        if (rsv_vld) m_busy[rsv_addr] = 1'b1;
        if (flush)
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_dirty = (wp_vld != 0) || (m_dirty && !fs_clean);
    endtask

    task automatic tick(input string tag);
        #1 check_reads(tag);
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic idle();
        rp_addr = '0;
        rp_fmt = 3'b111;
        wp_vld = '0;
        wp_addr = '0;
        wp_fmt = '0;
        wp_data = '0;
        rsv_vld = 1'b0;
        rsv_addr = '0;
        flush = 1'b0;
        fs_clean = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) begin
            logic [4:0] a;
            a = r[4:0];
            rp_addr = {a, a, a};
            #1 check_reads("rst_rd");
        end
        @(posedge clk);
        #1;
        chk("rst_fs", fs_dirty, 1'b0);
        rp_addr[0] = 5'd3;
        rp_fmt[0] = 1'b0;
        #1 chk("rst_s_f3", rp_data[0], CNAN_BOX);

        idle();
        wp_vld = 2'b01; wp_addr[0] = 5'd5; wp_fmt[0] = 1'b0; wp_data[0] = 64'hDEAD_BEEF_3F80_0000;
        tick("wr_s_f5");
        idle();
        rp_addr[0] = 5'd5; rp_addr[1] = 5'd5; rp_fmt = 3'b101;
        #1 chk("f5_d", rp_data[0], 64'hFFFF_FFFF_3F80_0000);
        chk("f5_s", rp_data[1], 64'hFFFF_FFFF_3F80_0000);

        idle();
        wp_vld = 2'b01; wp_addr[0] = 5'd7; wp_fmt[0] = 1'b1; wp_data[0] = 64'h4000_0000_0000_0000;
        tick("wr_d_f7");
        idle();
        rp_addr[0] = 5'd7; rp_fmt[0] = 1'b0;
        #1 chk("f7_s_nan", rp_data[0], CNAN_BOX);

        idle();
        wp_vld = 2'b11; wp_addr = {5'd9, 5'd9}; wp_fmt = 2'b11;
        wp_data = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        rp_addr[0] = 5'd9;
        #1 chk("f9_bypass", rp_data[0], 64'h2222_2222_2222_2222);
        tick("col_f9");
        idle();
        rp_addr[0] = 5'd9;
        #1 chk("f9_stored", rp_data[0], 64'h2222_2222_2222_2222);

        idle();
        rsv_vld = 1'b1; rsv_addr = 5'd12;
        tick("rsv_f12");
        idle();
        rp_addr[0] = 5'd12;
        #1 chk("f12_busy", rp_busy[0], 1'b1);
        wp_vld = 2'b01; wp_addr[0] = 5'd12; wp_fmt[0] = 1'b1; wp_data[0] = 64'h1234;
        rsv_vld = 1'b1; rsv_addr = 5'd12;
        tick("wr_rsv_f12");
        idle();
        rp_addr[0] = 5'd12;
        #1 chk("f12_still_busy", rp_busy[0], 1'b1);
        wp_vld = 2'b10; wp_addr[1] = 5'd12; wp_fmt[1] = 1'b1; wp_data[1] = 64'h5678;
        tick("wr_f12");
        idle();
        rp_addr[0] = 5'd12;
        #1 chk("f12_clear", rp_busy[0], 1'b0);
        rsv_vld = 1'b1; rsv_addr = 5'd1;
        tick("rsv_f1");
        rsv_vld = 1'b1; rsv_addr = 5'd2; flush = 1'b1;
        tick("rsv_f2_flush");
        idle();
        rp_addr[0] = 5'd1; rp_addr[1] = 5'd2;
        #1 chk("f1_flushed", rp_busy[0], 1'b0);
        chk("f2_flushed", rp_busy[1], 1'b0);

        chk("fs_set", fs_dirty, 1'b1);
        fs_clean = 1'b1; wp_vld = 2'b01; wp_addr[0] = 5'd4; wp_fmt[0] = 1'b0; wp_data[0] = 64'h42;
        tick("clean_wr");
        idle();
        #1 chk("fs_set_wins", fs_dirty, 1'b1);
        fs_clean = 1'b1;
        tick("clean");
        idle();
        #1 chk("fs_cleared", fs_dirty, 1'b0);

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 3; p++) rp_addr[p] = 5'($urandom_range(0, 7));
            rp_fmt = 3'($urandom);
            wp_vld = 2'($urandom);
            for (int i = 0; i < 2; i++) begin
                wp_addr[i] = 5'($urandom_range(0, 7));
                wp_data[i] = {$urandom, $urandom};
                if ($urandom_range(0, 3) == 0) wp_data[i][63:32] = 32'hFFFF_FFFF;
            end
            wp_fmt = 2'($urandom);
            rsv_vld = ($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            fs_clean = ($urandom_range(0, 7) == 0);
            tick("rnd");
        end

        idle();
        wp_vld = 2'b01; wp_addr[0] = 5'd20; wp_fmt[0] = 1'b1; wp_data[0] = 64'hCAFE_F00D_0000_0001;
        tick("pre_rst_wr");
        wp_vld = 2'b11; wp_addr = {5'd21, 5'd20}; wp_fmt = 2'b11;
        wp_data = {64'h77, 64'h99};
        rsv_vld = 1'b1; rsv_addr = 5'd22;
        #2 rst_n = 1'b0;
        #1 idle();
        model_reset();
        rp_addr[0] = 5'd20; rp_addr[1] = 5'd22; rp_addr[2] = 5'd12;
        #1 chk("mid_rst_f20", rp_data[0], 64'h0);
        chk("mid_rst_busy22", rp_busy[1], 1'b0);
        chk("mid_rst_fs", fs_dirty, 1'b0);
        check_reads("mid_rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check_reads("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv0_rf_f_mp.md
# rv0_rf_f_mp

Parametrised multi-ported floating-point register file for the rv0 core: NREG entries of FLEN bits, NRP combinational read ports, NWP registered write ports. It adds NaN-boxing/unboxing for single precision on an FLEN=64 file, a per-register busy scoreboard for long-latency FPU results, and mstatus.FS dirty tracking. It sits between FP decode/issue (reads, reservations) and FPU/FP-load writeback (writes).

## Interface
- FLEN, 64: register width; 32 or 64.
- NREG, 32: number of registers; power of two, index width AW = log2(NREG).
- NRP, 3: read ports (3 covers fused multiply-add).
- NWP, 2: write ports (FPU, load unit).
- BYPASS, 1: 1 = same-cycle write data forwarded to reads.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- rp_addr  in  NRP×AW  read addresses.
- rp_fmt  in  NRP×1  0 = S, 1 = D.
- rp_data  out  NRP×FLEN  read data.
- rp_busy  out  NRP×1  addressed register has a pending producer.
- wp_vld  in  NWP×1  write enable.
- wp_addr  in  NWP×AW  write addresses.
- wp_fmt  in  NWP×1  0 = S, 1 = D.
- wp_data  in  NWP×FLEN  write data; only [31:0] used when wp_fmt = S.
- rsv_vld  in  1  issue reserves a destination.
- rsv_addr  in  AW  reserved destination.
- flush  in  1  pipeline flush; clears all busy bits.
- fs_clean  in  1  CSR write sets mstatus.FS to Clean.
- fs_dirty  out  1  a write has occurred since reset or the last fs_clean.

## Operation
- Reset: all registers, busy bits and fs_dirty go to 0; rp_busy = 0; rp_data = 0, or the canonical NaN for S reads on FLEN=64, since 0 is not properly boxed.
- Write: on a clock edge with wp_vld[i], reg[wp_addr[i]] is loaded.
  - S on FLEN=64 stores {32'hFFFF_FFFF, wp_data[31:0]}.
  - D stores wp_data.
  - With FLEN=32, wp_fmt = D is illegal and is flagged by an assertion.
- Write collision (two ports, same address, same cycle): the highest port index wins.
- Read, D or FLEN=32: rp_data = reg.
- Read, S on FLEN=64:
  - upper 32 bits all-ones: rp_data = {32'hFFFF_FFFF, reg[31:0]};
  - otherwise: rp_data = {32'hFFFF_FFFF, 32'h7FC0_0000} (canonical NaN).
- Bypass (BYPASS=1): a read whose address matches a same-cycle valid write returns the post-write value, with boxing applied. The highest matching port wins.
- Scoreboard:
  - busy[rsv_addr] is set on the edge with rsv_vld.
  - busy[wp_addr[i]] is cleared on the edge with wp_vld[i].
  - Priority: flush > rsv > write clear. Reservation and write to the same address in the same cycle leave busy = 1.
  - flush clears every busy bit and drops a same-cycle rsv_vld. Register contents are not affected.
- rp_busy = busy[rp_addr]. With BYPASS=1 it is additionally masked by a same-cycle write to that address.
- fs_dirty:
  - set on the edge after any wp_vld;
  - cleared by fs_clean;
  - set wins when both occur in the same cycle.
- No x0-style hardwired register: f0 is an ordinary register.

## Timing
- Read: 0-cycle combinational, addr → data/busy.
- Write: visible on the read port the cycle after the edge (BYPASS=0), or the same cycle (BYPASS=1).
- Reservation: rp_busy asserts the cycle after rsv_vld.
- fs_dirty: asserts the cycle after the first write.
- Reset is asynchronous assert; deassertion is synchronised externally.
- Reset mid-operation: all state returns to reset values immediately, and pending reservations are lost.

## Structure
- Shared package rv0_pkg holds:
  - fp_fmt_t enum (FMT_S, FMT_D);
  - constant RV0_FP_CNAN_S = 32'h7FC0_0000;
  - constant RV0_FP_BOX = 32'hFFFF_FFFF;
  - default FLEN constant.
- Sub-module rv0_rf_f_rp: one read port, instantiated NRP times. It contains the address mux, bypass selection and unboxing.
- Storage, write-priority logic, scoreboard and FS tracking live in the top level.

## Test plan
- Reset, then read f0..f31 as D → all 0, rp_busy = 0, fs_dirty = 0; S read of f3 → 64'hFFFFFFFF_7FC00000.
- S write f5 = 32'h3F80_0000, then D read f5 → 64'hFFFFFFFF_3F800000; S read f5 → same.
- D write f7 = 64'h4000_0000_0000_0000, then S read f7 → canonical-NaN box (not properly boxed).
- Ports 0 and 1 both write f9 (0x1111…, 0x2222…) in the same cycle → f9 = 0x2222…; BYPASS=1 same-cycle read of f9 returns 0x2222….
- rsv f12 → rp_busy(f12) = 1 next cycle. Write f12 plus rsv f12 in the same cycle → still busy. Write alone → busy clears. Then rsv f1, f2 with flush → all busy = 0.
- Write any register → fs_dirty = 1. fs_clean with a same-cycle write → stays 1. fs_clean alone → 0. rst_n pulled low mid-write → immediate reset values.
